// File: rtl/life_core_param_if.sv
// ---------------------------------------------------------------------------
// life_core_param_if
// Control/status bundle between the life engine and its surroundings
// (control logic, VGA pixel path).
//
// Signals:
//   run, step, randomize, clear  command inputs to the core
//   wrap_en                      1 = toroidal board, 0 = dead border
//   birth_mask, survive_mask     rule masks, bit n applies to n neighbours
//   vsync_in                     display vsync, gates the start of a generation
//   rd_x, rd_y -> rd_cell        combinational display read port
//   busy, gen_count, pop_count   status outputs of the core
//   stable                       only present with LIFE_STABLE_DETECT_EN
//
// Modports: master drives commands (control side / bench), slave is the core.
// LOG_W/LOG_H must match the parameters of the attached life_core_param.
// ---------------------------------------------------------------------------
interface life_core_param_if #(
    parameter int LOG_W = 6,
    parameter int LOG_H = 5
);
    logic                   run;
    logic                   step;
    logic                   randomize;
    logic                   clear;
    logic                   wrap_en;
    logic [8:0]             birth_mask;
    logic [8:0]             survive_mask;
    logic                   vsync_in;
    logic [LOG_W-1:0]       rd_x;
    logic [LOG_H-1:0]       rd_y;
    logic                   rd_cell;
    logic                   busy;
    logic [15:0]            gen_count;
    logic [LOG_W+LOG_H:0]   pop_count;
`ifdef LIFE_STABLE_DETECT_EN
    logic                   stable;

    modport master (
        output run, step, randomize, clear, wrap_en, birth_mask, survive_mask,
               vsync_in, rd_x, rd_y,
        input  rd_cell, busy, gen_count, pop_count, stable
    );

    modport slave (
        input  run, step, randomize, clear, wrap_en, birth_mask, survive_mask,
               vsync_in, rd_x, rd_y,
        output rd_cell, busy, gen_count, pop_count, stable
    );
`else
    modport master (
        output run, step, randomize, clear, wrap_en, birth_mask, survive_mask,
               vsync_in, rd_x, rd_y,
        input  rd_cell, busy, gen_count, pop_count
    );

    modport slave (
        input  run, step, randomize, clear, wrap_en, birth_mask, survive_mask,
               vsync_in, rd_x, rd_y,
        output rd_cell, busy, gen_count, pop_count
    );
`endif
endinterface

// File: rtl/life_core_param.sv
// ---------------------------------------------------------------------------
// life_core_param
// Conway-style cellular automaton engine for the VGA life demo.
// Two board banks are kept; the display reads bank bankSel_q while a
// generation pass writes the other bank, then the banks swap (no copy phase).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    life_core_param_if.slave: commands, rule masks, display read port,
//          busy / gen_count / pop_count status
//
// Optional feature macro: LIFE_STABLE_DETECT_EN
//   Adds bus.stable, set at a bank swap when the new generation equals the
//   old one; while set, timer-driven generations are suppressed.
// ---------------------------------------------------------------------------
module life_core_param #(
    parameter int          LOG_W           = 6,
    parameter int          LOG_H           = 5,
    parameter int          UPDATE_INTERVAL = 2400000,
    parameter logic [15:0] LFSR_SEED       = 16'h0001
) (
    input logic                clk,
    input logic                rst_n,
    life_core_param_if.slave   bus
);

    localparam int CELLS_W = LOG_W + LOG_H;
    localparam int CELLS   = 1 << CELLS_W;
    localparam int POP_W   = CELLS_W + 1;
    localparam int TIMER_W = $clog2(UPDATE_INTERVAL + 1);
    localparam logic [TIMER_W-1:0] INTERVAL = TIMER_W'(UPDATE_INTERVAL);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        CLEAR,
        UPDATE
    } state_t;

    state_t               state_q, state_d;
    logic [CELLS_W-1:0]   idx_q, idx_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 bankSel_q, bankSel_d;
    logic [15:0]          genCount_q, genCount_d;
    logic [POP_W-1:0]     popCount_q, popCount_d;
    logic [POP_W-1:0]     popAcc_q, popAcc_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 stepPending_q, stepPending_d;
    logic                 wrapLat_q, wrapLat_d;
    logic [8:0]           birthLat_q, birthLat_d;
    logic [8:0]           survLat_q, survLat_d;

    logic [CELLS-1:0]     bank_q [2];
    logic [CELLS-1:0]     disp;

    logic                 wrEn;
    logic                 wrBank;
    logic                 wrData;

    logic [LOG_W-1:0]     curX, xm, xp;
    logic [LOG_H-1:0]     curY, ym, yp;
    logic                 xmOk, xpOk, ymOk, ypOk;
    logic [7:0]           nb;
    logic [3:0]           nSum;
    logic                 curCell;
    logic                 nextCell;
    logic                 isLast;
    logic                 timerGo;

`ifdef LIFE_STABLE_DETECT_EN
    logic                 stable_q, stable_d;
    logic                 allMatch_q, allMatch_d;
`endif

    // The displayed bank drives both the pixel read port and the
    // neighbourhood fetch, so a pass only ever reads the finished generation.
    assign disp        = bank_q[bankSel_q];
    assign bus.rd_cell = disp[{bus.rd_y, bus.rd_x}];

    assign bus.busy      = (state_q != IDLE);
    assign bus.gen_count = genCount_q;
    assign bus.pop_count = popCount_q;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11, shifting left into bit 0.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Neighbour coordinates wrap naturally in LOG_W/LOG_H bits; the *Ok
    // flags zero out wrapped neighbours when the board has a dead border.
    assign curX = idx_q[LOG_W-1:0];
    assign curY = idx_q[CELLS_W-1:LOG_W];
    assign xm   = curX - 1'b1;
    assign xp   = curX + 1'b1;
    assign ym   = curY - 1'b1;
    assign yp   = curY + 1'b1;
    assign xmOk = wrapLat_q | (curX != '0);
    assign xpOk = wrapLat_q | (curX != '1);
    assign ymOk = wrapLat_q | (curY != '0);
    assign ypOk = wrapLat_q | (curY != '1);

    assign nb[0] = disp[{ym, xm}]     & ymOk & xmOk;
    assign nb[1] = disp[{ym, curX}]   & ymOk;
    assign nb[2] = disp[{ym, xp}]     & ymOk & xpOk;
    assign nb[3] = disp[{curY, xm}]   & xmOk;
    assign nb[4] = disp[{curY, xp}]   & xpOk;
    assign nb[5] = disp[{yp, xm}]     & ypOk & xmOk;
    assign nb[6] = disp[{yp, curX}]   & ypOk;
    assign nb[7] = disp[{yp, xp}]     & ypOk & xpOk;

    // Neighbour population 0..8 for the cell at idx_q.
    always_comb begin
        nSum = '0;
        for (int i = 0; i < 8; i++) begin
            nSum = nSum + 4'(nb[i]);
        end
    end

    assign curCell  = disp[idx_q];
    assign nextCell = curCell ? survLat_q[nSum] : birthLat_q[nSum];
    assign isLast   = (idx_q == '1);

`ifdef LIFE_STABLE_DETECT_EN
    assign timerGo    = bus.run & (timer_q >= INTERVAL) & ~stable_q;
    assign bus.stable = stable_q;
`else
    assign timerGo    = bus.run & (timer_q >= INTERVAL);
`endif

    // Next-state and datapath control. Every pass walks idx_q over all cells
    // at one cell per cycle; the final cell's edge also finishes the pass.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        bankSel_d     = bankSel_q;
        genCount_d    = genCount_q;
        popCount_d    = popCount_q;
        popAcc_d      = popAcc_q;
        timer_d       = timer_q;
        stepPending_d = stepPending_q;
        wrapLat_d     = wrapLat_q;
        birthLat_d    = birthLat_q;
        survLat_d     = survLat_q;
        wrEn          = 1'b0;
        wrBank        = bankSel_q;
        wrData        = 1'b0;
`ifdef LIFE_STABLE_DETECT_EN
        stable_d      = stable_q;
        allMatch_d    = allMatch_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.run && (timer_q < INTERVAL)) begin
                    timer_d = timer_q + 1'b1;
                end
                if (bus.step) begin
                    stepPending_d = 1'b1;
                end
                if (bus.clear) begin
                    state_d    = CLEAR;
                    idx_d      = '0;
                    genCount_d = '0;
                    popCount_d = '0;
`ifdef LIFE_STABLE_DETECT_EN
                    stable_d   = 1'b0;
`endif
                end else if (bus.randomize) begin
                    state_d    = INIT;
                    idx_d      = '0;
                    popAcc_d   = '0;
                    genCount_d = '0;
`ifdef LIFE_STABLE_DETECT_EN
                    stable_d   = 1'b0;
`endif
                end else if ((stepPending_q || bus.step || timerGo) && bus.vsync_in) begin
                    state_d       = UPDATE;
                    idx_d         = '0;
                    popAcc_d      = '0;
                    timer_d       = '0;
                    stepPending_d = 1'b0;
                    wrapLat_d     = bus.wrap_en;
                    birthLat_d    = bus.birth_mask;
                    survLat_d     = bus.survive_mask;
`ifdef LIFE_STABLE_DETECT_EN
                    allMatch_d    = 1'b1;
`endif
                end
            end

            INIT: begin
                wrEn     = 1'b1;
                wrBank   = bankSel_q;
                wrData   = lfsr_q[0];
                popAcc_d = popAcc_q + POP_W'(wrData);
                idx_d    = idx_q + 1'b1;
                if (isLast) begin
                    state_d    = IDLE;
                    popCount_d = popAcc_d;
                    genCount_d = '0;
                end
            end

            CLEAR: begin
                wrEn   = 1'b1;
                wrBank = bankSel_q;
                wrData = 1'b0;
                idx_d  = idx_q + 1'b1;
                if (isLast) begin
                    state_d    = IDLE;
                    popCount_d = '0;
                    genCount_d = '0;
                end
            end

            UPDATE: begin
                wrEn     = 1'b1;
                wrBank   = ~bankSel_q;
                wrData   = nextCell;
                popAcc_d = popAcc_q + POP_W'(wrData);
                idx_d    = idx_q + 1'b1;
`ifdef LIFE_STABLE_DETECT_EN
                allMatch_d = allMatch_q & (nextCell == curCell);
`endif
                if (isLast) begin
                    state_d    = IDLE;
                    bankSel_d  = ~bankSel_q;
                    genCount_d = genCount_q + 16'd1;
                    popCount_d = popAcc_d;
`ifdef LIFE_STABLE_DETECT_EN
                    stable_d   = allMatch_d;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers; reset restarts with a fresh INIT pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            idx_q         <= '0;
            lfsr_q        <= LFSR_SEED;
            bankSel_q     <= 1'b0;
            genCount_q    <= '0;
            popCount_q    <= '0;
            popAcc_q      <= '0;
            timer_q       <= '0;
            stepPending_q <= 1'b0;
            wrapLat_q     <= 1'b0;
            birthLat_q    <= '0;
            survLat_q     <= '0;
`ifdef LIFE_STABLE_DETECT_EN
            stable_q      <= 1'b0;
            allMatch_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            lfsr_q        <= lfsr_d;
            bankSel_q     <= bankSel_d;
            genCount_q    <= genCount_d;
            popCount_q    <= popCount_d;
            popAcc_q      <= popAcc_d;
            timer_q       <= timer_d;
            stepPending_q <= stepPending_d;
            wrapLat_q     <= wrapLat_d;
            birthLat_q    <= birthLat_d;
            survLat_q     <= survLat_d;
`ifdef LIFE_STABLE_DETECT_EN
            stable_q      <= stable_d;
            allMatch_q    <= allMatch_d;
`endif
        end
    end

    // Board storage carries no reset; writes are held off while rst_n is low
    // so an aborted pass leaves nothing behind that INIT will not overwrite.
    always_ff @(posedge clk) begin
        if (wrEn && rst_n) begin
            bank_q[wrBank][idx_q] <= wrData;
        end
    end

endmodule

// File: tb/tb_life_core_param.sv
// ---------------------------------------------------------------------------
// tb_life_core_param
// Self-checking bench for life_core_param. A behavioural board model (2-D
// array, neighbour counting with modular arithmetic) is advanced alongside
// the core and compared through the display read port. The INIT pattern is
// predicted from the LFSR polynomial.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_life_core_param;

    localparam int          LOG_W    = 6;
    localparam int          LOG_H    = 5;
    localparam int          W        = 1 << LOG_W;
    localparam int          H        = 1 << LOG_H;
    localparam int          CELLS    = W * H;
    localparam int          INTERVAL = 8;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic clk;
    logic rst_n;

    life_core_param_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();

    life_core_param #(
        .LOG_W           (LOG_W),
        .LOG_H           (LOG_H),
        .UPDATE_INTERVAL (INTERVAL),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          expGen;
    bit          model [H][W];
    logic [15:0] lfsrModel;
    logic [15:0] seedCap;

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Tracks the free-running LFSR so a randomize reseed can be predicted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsrModel <= SEED;
        else        lfsrModel <= lfsrNext(lfsrModel);
    end

    // Fill the model board with the LFSR bit stream, cell k = {y,x} row-major.
    task automatic fillFromLfsr(input logic [15:0] start);
        logic [15:0] s;
        s = start;
        for (int k = 0; k < CELLS; k++) begin
            model[k / W][k % W] = s[0];
            s = lfsrNext(s);
        end
    endtask

    task automatic clearModel();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                model[y][x] = 1'b0;
    endtask

    function automatic int modelPop();
        int p = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                p += int'(model[y][x]);
        return p;
    endfunction

    // One generation of the reference automaton.
    task automatic stepModel(input bit wrap, input logic [8:0] birth, input logic [8:0] surv);
        bit nxt [H][W];
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int yy = y + dy;
                        int xx = x + dx;
                        if (dy == 0 && dx == 0) continue;
                        if (wrap) begin
                            yy = (yy + H) % H;
                            xx = (xx + W) % W;
                        end else if (yy < 0 || yy >= H || xx < 0 || xx >= W) begin
                            continue;
                        end
                        n += int'(model[yy][xx]);
                    end
                end
                nxt[y][x] = model[y][x] ? surv[n] : birth[n];
            end
        end
        model = nxt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Scan the displayed bank through rd_x/rd_y and compare with the model.
    task automatic checkBoard(input string tag);
        int miss = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                bus.rd_x = LOG_W'(x);
                bus.rd_y = LOG_H'(y);
                #1;
                if (bus.rd_cell !== model[y][x]) miss++;
            end
        end
        checkOutput({tag, "Cells"}, miss, 0);
        checkOutput({tag, "Pop"}, 32'(bus.pop_count), modelPop());
        checkOutput({tag, "Gen"}, 32'(bus.gen_count), expGen);
    endtask

    // One-cycle command pulse launched and removed on falling edges.
    task automatic applyStimulus(input bit doStep, input bit doClear, input bit doRand);
        @(negedge clk);
        bus.step      = doStep;
        bus.clear     = doClear;
        bus.randomize = doRand;
        @(negedge clk);
        bus.step      = 1'b0;
        bus.clear     = 1'b0;
        bus.randomize = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "Idle"}, 32'(bus.busy), 0);
    endtask

    task automatic waitGen(input string tag, input int target);
        int n = 0;
        while (32'(bus.gen_count) !== target && n < 10000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "GenReach"}, 32'(bus.gen_count), target);
    endtask

    // Single-step one generation; masks are scrambled mid-pass to show the
    // pass keeps using the values latched at its start.
    task automatic doGeneration(input string tag, input bit wrap, input logic [8:0] b, input logic [8:0] s);
        bus.wrap_en      = wrap;
        bus.birth_mask   = b;
        bus.survive_mask = s;
        applyStimulus(1'b1, 1'b0, 1'b0);
        bus.wrap_en      = ~wrap;
        bus.birth_mask   = 9'($urandom);
        bus.survive_mask = 9'($urandom);
        waitGen(tag, expGen + 1);
        waitIdle(tag);
        expGen++;
        stepModel(wrap, b, s);
        checkBoard(tag);
    endtask

    initial begin
        int target;
        rst_n            = 1'b0;
        bus.run          = 1'b0;
        bus.step         = 1'b0;
        bus.randomize    = 1'b0;
        bus.clear        = 1'b0;
        bus.wrap_en      = 1'b0;
        bus.birth_mask   = 9'b000001000;
        bus.survive_mask = 9'b000001100;
        bus.vsync_in     = 1'b1;
        bus.rd_x         = '0;
        bus.rd_y         = '0;
        expGen           = 0;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 32'(bus.busy), 1);
        checkOutput("rstGen", 32'(bus.gen_count), 0);
        checkOutput("rstPop", 32'(bus.pop_count), 0);

        // INIT after release lasts exactly W*H cycles.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (CELLS - 1) @(posedge clk);
        #1 checkOutput("initBusyLast", 32'(bus.busy), 1);
        @(posedge clk);
        #1 checkOutput("initBusyDone", 32'(bus.busy), 0);
        fillFromLfsr(SEED);
        checkBoard("init");

        // A step pulse without vsync waits, then runs once vsync arrives.
        bus.vsync_in = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("vsyncHoldGen", 32'(bus.gen_count), expGen);
        checkOutput("vsyncHoldBusy", 32'(bus.busy), 0);
        bus.vsync_in = 1'b1;
        waitGen("vsync", expGen + 1);
        waitIdle("vsync");
        expGen++;
        stepModel(1'b0, 9'b000001000, 9'b000001100);
        checkBoard("vsync");

        // Random rules and border mode on the random board.
        for (int i = 0; i < 3; i++) begin
            doGeneration("rand", 1'($urandom), 9'($urandom), 9'($urandom));
        end

        // Timer-driven auto run, B36/S23 on a torus, stopped after two passes.
        bus.wrap_en      = 1'b1;
        bus.birth_mask   = 9'b001001000;
        bus.survive_mask = 9'b000001100;
        bus.run          = 1'b1;
        target           = expGen + 2;
        waitGen("run", target);
        bus.run = 1'b0;
        waitIdle("run");
        expGen += 2;
        stepModel(1'b1, 9'b001001000, 9'b000001100);
        stepModel(1'b1, 9'b001001000, 9'b000001100);
        checkBoard("run");

        // clear wins over randomize; a step during CLEAR is dropped.
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitIdle("clr");
        expGen = 0;
        clearModel();
        checkBoard("clr");
        repeat (40) @(negedge clk);
        checkOutput("clrStepDropped", 32'(bus.gen_count), 0);

        // B0 fills the whole board: pop_count reaches W*H.
        doGeneration("fill", 1'b0, 9'b000000001, 9'b000000000);
        checkOutput("fillPopFull", 32'(bus.pop_count), CELLS);

        // From a full board with a dead border only the four corners survive.
        doGeneration("corner", 1'b0, 9'b000001000, 9'b000001100);

        // randomize reseeds from the LFSR value current when INIT starts.
        @(negedge clk);
        bus.randomize = 1'b1;
        @(posedge clk);
        #1 seedCap = lfsrModel;
        bus.randomize = 1'b0;
        waitIdle("reinit");
        expGen = 0;
        fillFromLfsr(seedCap);
        checkBoard("reinit");

`ifdef LIFE_STABLE_DETECT_EN
        // An empty board is a still life: auto-run stops, step still works.
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitIdle("stClr");
        checkOutput("stableAfterClear", 32'(bus.stable), 0);
        expGen = 0;
        clearModel();
        doGeneration("stable", 1'b0, 9'b000001000, 9'b000001100);
        checkOutput("stableSet", 32'(bus.stable), 1);
        bus.run = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("stableNoAuto", 32'(bus.gen_count), 1);
        bus.run = 1'b0;
        doGeneration("stableStep", 1'b0, 9'b000001000, 9'b000001100);
        checkOutput("stableStepGen", 32'(bus.gen_count), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_core_param.md
Name: life_core_param

Overview:
- Parametrised Conway-style cellular automaton engine for the VGA life demo.
- Double-buffered board (no copy phase) with programmable birth/survive rules, wrap or dead-edge boundary, single-step, clear, random seeding, generation and population counters.
- Sits between the control inputs and the VGA pixel path. The pixel path reads the displayed bank through a combinational read port.

Parameters:
- LOG_W, 6, log2 board width in cells (W = 2**LOG_W).
- LOG_H, 5, log2 board height in cells (H = 2**LOG_H).
- UPDATE_INTERVAL, 2400000, clk cycles between auto-run generations (10 Hz at 24 MHz).
- LFSR_SEED, 16'h0001, non-zero reset seed of the 16-bit LFSR.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- run  in  1  level; high enables timed auto-generation.
- step  in  1  single-cycle pulse; requests one generation.
- randomize  in  1  level; request random reseed.
- clear  in  1  level; request all-dead board.
- wrap_en  in  1  1 = toroidal edges, 0 = cells outside the board read as dead.
- birth_mask  in  9  bit n set = dead cell with n neighbours becomes live.
- survive_mask  in  9  bit n set = live cell with n neighbours stays live.
- vsync_in  in  1  display vsync; gates generation start.
- rd_x  in  LOG_W  display read column.
- rd_y  in  LOG_H  display read row.
- rd_cell  out  1  combinational state of (rd_x, rd_y) in the displayed bank.
- busy  out  1  high whenever the FSM is not in IDLE.
- gen_count  out  16  generations completed since reset/init/clear; wraps at 16'hFFFF to 0.
- pop_count  out  LOG_W+LOG_H+1  live cells in the displayed bank.

Behaviour:
- Storage: two banks of W*H bits; bank_sel selects the displayed bank.
- Cell index = {y, x}.
- Writes go to ~bank_sel during UPDATE, and to bank_sel during INIT and CLEAR.
- FSM states: IDLE, INIT, CLEAR, UPDATE.
- After rst_n deasserts, the FSM goes to INIT.
- On reset: bank_sel=0, busy=1 (state INIT), gen_count=0, pop_count=0, timer=0, idx=0, LFSR=LFSR_SEED. Bank contents are not reset.
- Command selection in IDLE, in priority order:
  - clear -> CLEAR.
  - randomize -> INIT.
  - pending step, or (run and timer>=UPDATE_INTERVAL) -> wait for vsync_in=1, then UPDATE.
- Timer:
  - Increments while run=1 in IDLE, saturating at UPDATE_INTERVAL.
  - Clears on entry to UPDATE.
- step:
  - A pulse in IDLE sets step_pending; cleared on entry to UPDATE.
  - Pulses seen while busy are dropped.
- INIT:
  - One cell per cycle, writes LFSR[0].
  - Takes W*H cycles, then IDLE.
  - gen_count set to 0; pop_count set to the number of live cells written.
- CLEAR:
  - One cell per cycle, writes 0.
  - Takes W*H cycles, then IDLE.
  - gen_count=0, pop_count=0.
- UPDATE, one cell per cycle:
  - Reads the 8 neighbours combinationally from bank_sel.
  - n = neighbour sum, 0..8.
  - next = cur ? survive_mask[n] : birth_mask[n].
  - Writes next to ~bank_sel[idx].
  - After W*H cycles, on the same final edge: bank_sel toggles, gen_count increments, pop_count loads the accumulated live count, FSM returns to IDLE.
- wrap_en, birth_mask and survive_mask are latched on UPDATE entry and held constant for the whole pass.
- Boundary with wrap_en=0: coordinates -1 or W/H contribute 0. With wrap_en=1: indices wrap modulo W/H.
- rd_cell always reflects bank_sel, so the display never shows a partially updated generation.
- The LFSR steps every clk in all states. Polynomial is x^16+x^14+x^13+x^11, shifting left, feedback into bit 0.
- Reset mid-operation: the FSM aborts immediately and re-enters INIT after release. The partially written bank is overwritten by INIT.
- pop_count width accommodates the value W*H (all-live board).

Optional Feature:
- Macro LIFE_STABLE_DETECT_EN.
- When defined:
  - Adds output port stable (1 bit, reset 0).
  - During UPDATE each written next bit is compared with cur. If every cell matches, stable=1 at bank swap, else stable=0.
  - While stable=1, timer-driven generations are suppressed; step still works.
  - INIT and CLEAR force stable=0.
- When undefined: no port and no comparator; auto-run continues indefinitely.

Test Plan:
- Reset, run=0 -> busy=1 for exactly W*H=2048 cycles, then busy=0, gen_count=0, pop_count equals the live cells read back via rd_x/rd_y scan.
- clear, then preload a blinker at (10,10)-(12,10) via a bench backdoor, B3/S23, wrap_en=0, two step pulses -> vertical blinker at (11,9)-(11,11), then horizontal again; pop_count=3; gen_count=2.
- Glider at the bottom-right corner, wrap_en=1, run=1, UPDATE_INTERVAL=8 -> after 4*W generations the glider is back at its start pattern; with wrap_en=0 it becomes a 2x2 block (pop_count=4).
- birth_mask=9'b001001000 (B36), survive_mask=9'b000001100 (S23), 3x3 seeded test patch -> every cell matches the golden model each generation.
- clear and randomize both high in IDLE -> CLEAR is taken, pop_count=0; a step pulse while busy is ignored, so gen_count is unchanged.
- LIFE_STABLE_DETECT_EN defined, 2x2 block, run=1 -> stable=1 after generation 1 and gen_count stays 1 with no further UPDATE; a step pulse -> gen_count=2.
